// File: rtl/sweep_gen_multi.sv
// Multi-channel signed ramp generator (sawtooth / triangle / hold) for the
// DAC data path. Each channel owns a fractional accumulator; new settings are
// double-buffered in a shadow register and take effect at that channel's
// cycle boundary, on a global sync, or at once when the channel is idle.
module sweep_gen_multi #(
    parameter int unsigned NCH  = 2,
    parameter int unsigned W    = 16,
    parameter int unsigned FRAC = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    load_in,
    input  logic [NCH*W-1:0]        min_cfg,
    input  logic [NCH*W-1:0]        max_cfg,
    input  logic [NCH*(W+FRAC)-1:0] step_cfg,
    input  logic [NCH*2-1:0]        mode_cfg,
    input  logic [NCH-1:0]          on_in,
    input  logic                    sync_in,
    output logic [NCH*W-1:0]        signal_out,
    output logic [NCH-1:0]          cycle_out,
    output logic [NCH-1:0]          pending_out
);

    localparam int unsigned AW = W + FRAC;   // accumulator width
    localparam int unsigned NW = AW + 1;     // next-value width, one guard bit
    localparam int unsigned IW = NW - FRAC;  // integer part of the next value

    localparam logic [1:0] MODE_SAW  = 2'd0;
    localparam logic [1:0] MODE_TRI  = 2'd1;
    localparam logic [1:0] MODE_HOLD = 2'd2;  // 2 and 3 both hold

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef struct packed {
        logic [W-1:0]  min_v;
        logic [W-1:0]  max_v;
        logic [AW-1:0] step;
        logic [1:0]    mode;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{min_v: '0, max_v: '0, step: '0, mode: MODE_HOLD};

    for (genvar k = 0; k < NCH; k++) begin : g_ch

        cfg_t          act_q, act_d;
        cfg_t          shd_q, shd_d;
        cfg_t          cfg_in;
        cfg_t          nxt_cfg;
        logic [AW-1:0] acc_q, acc_d;
        dir_e          dir_q, dir_d;
        logic          pend_q, pend_d;
        logic [W-1:0]  sig_q, sig_d;
        logic          cyc_q, cyc_d;
        logic          restart;
        logic          apply;

        logic signed [NW-1:0] acc_s;
        logic signed [NW-1:0] step_s;
        logic signed [NW-1:0] up_s;
        logic signed [NW-1:0] dn_s;
        logic signed [IW-1:0] up_int;
        logic signed [IW-1:0] dn_int;
        logic signed [IW-1:0] min_s;
        logic signed [IW-1:0] max_s;

        // Slice this channel's configuration out of the flat input buses.
        always_comb begin
            cfg_in       = CFG_RESET;
            cfg_in.min_v = min_cfg[k*W +: W];
            cfg_in.max_v = max_cfg[k*W +: W];
            cfg_in.step  = step_cfg[k*AW +: AW];
            cfg_in.mode  = mode_cfg[k*2 +: 2];
        end

        // Candidate next values in one extra bit, and their integer parts.
        always_comb begin
            acc_s  = {acc_q[AW-1], acc_q};
            step_s = {1'b0, act_q.step};
            up_s   = acc_s + step_s;
            dn_s   = acc_s - step_s;
            up_int = up_s[NW-1:FRAC];
            dn_int = dn_s[NW-1:FRAC];
            min_s  = {act_q.min_v[W-1], act_q.min_v};
            max_s  = {act_q.max_v[W-1], act_q.max_v};
        end

        // Stepping, boundary detection, shadow apply and shadow load.
        always_comb begin
            act_d   = act_q;
            shd_d   = shd_q;
            acc_d   = acc_q;
            dir_d   = dir_q;
            pend_d  = pend_q;
            sig_d   = acc_q[AW-1 -: W];
            cyc_d   = 1'b0;
            restart = 1'b0;
            apply   = 1'b0;
            nxt_cfg = act_q;

            if (sync_in) begin
                restart = 1'b1;
                apply   = pend_q;
            end else if (!on_in[k] || (act_q.mode >= MODE_HOLD)) begin
                // Idle channel: nothing to wait for, take the shadow now.
                apply   = pend_q;
                restart = pend_q;
            end else if (min_s >= max_s) begin
                // Empty range: permanently sitting on its boundary.
                restart = 1'b1;
                apply   = pend_q;
                cyc_d   = 1'b1;
            end else if (act_q.mode == MODE_TRI) begin
                // Turn as soon as a bound is reached so no endpoint repeats.
                if (dir_q == DIR_UP) begin
                    if (up_int > max_s) begin
                        acc_d = {act_q.max_v, {FRAC{1'b0}}};
                        dir_d = DIR_DOWN;
                    end else begin
                        acc_d = up_s[AW-1:0];
                        if (up_int == max_s) begin
                            dir_d = DIR_DOWN;
                        end
                    end
                end else begin
                    if (dn_int <= min_s) begin
                        dir_d = DIR_UP;
                        cyc_d = 1'b1;
                        apply = pend_q;
                        if ((dn_int < min_s) || pend_q) begin
                            restart = 1'b1;
                        end else begin
                            acc_d = dn_s[AW-1:0];
                        end
                    end else begin
                        acc_d = dn_s[AW-1:0];
                    end
                end
            end else if (act_q.mode == MODE_SAW) begin
                if (up_int > max_s) begin
                    restart = 1'b1;
                    apply   = pend_q;
                    cyc_d   = 1'b1;
                end else begin
                    acc_d = up_s[AW-1:0];
                end
            end

            if (apply) begin
                nxt_cfg = shd_q;
                pend_d  = 1'b0;
            end
            act_d = nxt_cfg;

            if (restart) begin
                acc_d = {nxt_cfg.min_v, {FRAC{1'b0}}};
                dir_d = DIR_UP;
            end

            // A load coinciding with an apply stays pending for the next boundary.
            if (load_in) begin
                shd_d  = cfg_in;
                pend_d = 1'b1;
            end
        end

        // Channel state and output registers.
        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                act_q  <= CFG_RESET;
                shd_q  <= CFG_RESET;
                acc_q  <= '0;
                dir_q  <= DIR_UP;
                pend_q <= 1'b0;
                sig_q  <= '0;
                cyc_q  <= 1'b0;
            end else begin
                act_q  <= act_d;
                shd_q  <= shd_d;
                acc_q  <= acc_d;
                dir_q  <= dir_d;
                pend_q <= pend_d;
                sig_q  <= sig_d;
                cyc_q  <= cyc_d;
            end
        end

        assign signal_out[k*W +: W] = sig_q;
        assign cycle_out[k]         = cyc_q;
        assign pending_out[k]       = pend_q;
    end

endmodule
